router_sync_n: RTL and testbench
================================

ROUTER_SYNC_N -- requirements
Module: router_sync_n

Interface
REQ-001 Parameter NUM_CH, default 3: number of output channels/FIFOs, legal range 1..8.
REQ-002 Parameter ADDR_W, default 2: address field width, SHALL satisfy 2**ADDR_W >= NUM_CH.
REQ-003 Parameter TIMEOUT, default 30: stall cycles before channel soft reset, legal range 2..1023.
REQ-004 Port clock  in  1  sole clock, all state on rising edge.
REQ-005 Port resetn  in  1  asynchronous, active-low reset.
REQ-006 Port detect_add  in  1  header-byte strobe; address capture enable.
REQ-007 Port data_in  in  ADDR_W  destination address from header.
REQ-008 Port write_enb_reg  in  1  FSM write request for current packet.
REQ-009 Port full  in  NUM_CH  per-FIFO full flags.
REQ-010 Port empty  in  NUM_CH  per-FIFO empty flags.
REQ-011 Port read_enb  in  NUM_CH  per-channel consumer read strobes.
REQ-012 Port write_enb  out  NUM_CH  one-hot FIFO write enable.
REQ-013 Port fifo_full  out  1  full flag of addressed FIFO.
REQ-014 Port addr_err  out  1  last captured address >= NUM_CH.
REQ-015 Port vld_out  out  NUM_CH  per-channel data-valid.
REQ-016 Port soft_reset  out  NUM_CH  per-channel one-cycle timeout pulse.

Function
REQ-017 Address register addr_q SHALL load data_in on a rising edge with detect_add=1, else hold.
REQ-018 addr_err SHALL be registered: on detect_add edge, set to (data_in >= NUM_CH); else hold.
REQ-019 write_enb SHALL be combinational: one-hot bit addr_q when write_enb_reg=1 and addr_q < NUM_CH; all-zero otherwise.
REQ-020 fifo_full SHALL equal full[addr_q] when addr_q < NUM_CH, else 0, combinationally.
REQ-021 detect_add and write_enb_reg in the same cycle: decode SHALL use pre-edge addr_q (new address effective next cycle).
REQ-022 vld_out[i] SHALL equal ~empty[i] combinationally.
REQ-023 Per channel, count[i] (width clog2(TIMEOUT)) SHALL clear when empty[i]=1 or read_enb[i]=1, else increment.
REQ-024 When count[i]==TIMEOUT-1 and channel still stalled (vld_out=1, read_enb=0), next edge SHALL set soft_reset[i]=1 and count[i]=0.
REQ-025 soft_reset[i] SHALL be high exactly one cycle per timeout; continued stall re-pulses every TIMEOUT cycles.
REQ-026 read_enb[i]=1 on the same cycle as count==TIMEOUT-1 SHALL suppress the pulse and clear count.
REQ-027 Channels SHALL be fully independent; simultaneous timeouts on several channels pulse concurrently.
REQ-028 Counters SHALL never wrap past TIMEOUT-1.

Reset
REQ-029 resetn=0 SHALL asynchronously clear addr_q, addr_err, all count[i], all soft_reset[i] to 0.
REQ-030 During and after reset: write_enb=0 unless write_enb_reg=1 (addr 0 decoded); vld_out tracks empty.
REQ-031 Reset mid-stall SHALL restart the timeout from zero; no pulse is owed.

Structure
REQ-032 Package router_pkg SHALL hold NUM_CH/ADDR_W/TIMEOUT defaults and a clog2 constant function.
REQ-033 Sub-module router_timeout SHALL implement one channel counter plus pulse, instantiated NUM_CH times by generate.
REQ-034 Target size 120-400 RTL lines total.

Verification (NUM_CH=3, ADDR_W=2, TIMEOUT=30 unless stated)
REQ-035 detect_add with data_in=2, then write_enb_reg=1, full=3'b100 -> write_enb=3'b100, fifo_full=1, addr_err=0.
REQ-036 detect_add with data_in=3, write_enb_reg=1 -> write_enb=0, fifo_full=0, addr_err=1 until next detect_add.
REQ-037 empty[1]=0, read_enb[1]=0 for 65 cycles -> soft_reset[1] pulses one cycle after edges 30 and 60 only.
REQ-038 Stall channel 0 for 29 cycles, read_enb[0]=1 on cycle 30 -> no pulse; count returns 0.
REQ-039 resetn low 3 cycles at stall cycle 20 of channel 2 -> outputs cleared immediately; next pulse 30 cycles after release.
REQ-040 NUM_CH=5, ADDR_W=3, TIMEOUT=4, channels 0 and 4 stalled together -> simultaneous soft_reset pulses every 4 cycles.

Source files
------------

// File: rtl/router_pkg.sv
// Shared defaults and helpers for the router synchronizer slice.
//   NUM_CH_DEF  : default number of output channels/FIFOs
//   ADDR_W_DEF  : default width of the header address field
//   TIMEOUT_DEF : default stall cycles before a channel soft reset
//   clog2()     : constant function used to size per-channel stall counters
package router_pkg;

  localparam int NUM_CH_DEF  = 3;
  localparam int ADDR_W_DEF  = 2;
  localparam int TIMEOUT_DEF = 30;

  // Smallest width w with 2**w >= value; sizes a counter holding 0..value-1.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/router_sync_n_if.sv
// Bundle of handshake/status signals between the router FSM/FIFO side and
// the router synchronizer.
//   detect_add, data_in, write_enb_reg : header capture and write request
//   full, empty, read_enb              : per-FIFO status and consumer strobes
//   write_enb, fifo_full, addr_err     : decoded FIFO write side
//   vld_out, soft_reset                : per-channel valid and timeout pulse
// master drives the requests/status; slave is the synchronizer.
interface router_sync_n_if
  import router_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              detect_add;
  logic [ADDR_W-1:0] data_in;
  logic              write_enb_reg;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] read_enb;
  logic [NUM_CH-1:0] write_enb;
  logic              fifo_full;
  logic              addr_err;
  logic [NUM_CH-1:0] vld_out;
  logic [NUM_CH-1:0] soft_reset;

  modport master (
    output detect_add, data_in, write_enb_reg, full, empty, read_enb,
    input  write_enb, fifo_full, addr_err, vld_out, soft_reset
  );

  modport slave (
    input  detect_add, data_in, write_enb_reg, full, empty, read_enb,
    output write_enb, fifo_full, addr_err, vld_out, soft_reset
  );

endinterface

// File: rtl/router_timeout.sv
// One channel's stall watchdog. Counts cycles where the channel holds data
// (empty_i=0) and nobody reads it; after TIMEOUT such cycles it emits a
// one-cycle soft_reset_o pulse and restarts counting.
//   clock, resetn : clock and asynchronous active-low reset
//   empty_i       : FIFO empty flag for this channel
//   read_enb_i    : consumer read strobe for this channel
//   soft_reset_o  : registered one-cycle timeout pulse
module router_timeout
  import router_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clock,
  input  logic resetn,
  input  logic empty_i,
  input  logic read_enb_i,
  output logic soft_reset_o
);

  localparam int                 CNT_W    = clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             soft_reset_q, soft_reset_d;
  logic             stalled;

  assign stalled = ~empty_i & ~read_enb_i;

  always_comb begin
    // NOTE: every next-state variable gets a default before any branch, so
    // no path leaves it unassigned and no latch is inferred.
    count_d      = '0;
    soft_reset_d = 1'b0;
    if (stalled) begin
      // Terminal count pulses and restarts from zero rather than wrapping.
      if (count_q == CNT_LAST) soft_reset_d = 1'b1;
      else                     count_d      = count_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments and clear on the
  // asynchronous reset, so a reset mid-stall restarts the timeout cleanly.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count_q      <= '0;
      soft_reset_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      soft_reset_q <= soft_reset_d;
    end
  end

  assign soft_reset_o = soft_reset_q;

endmodule

// File: rtl/router_sync_n.sv
// Router synchronizer: latches the packet destination from the header byte,
// decodes it into a one-hot FIFO write enable and the addressed full flag,
// flags out-of-range addresses, and runs an independent stall watchdog per
// output channel.
//   clock, resetn : clock and asynchronous active-low reset
//   bus (slave)   : detect_add/data_in/write_enb_reg/full/empty/read_enb in,
//                   write_enb/fifo_full/addr_err/vld_out/soft_reset out
module router_sync_n
  import router_pkg::*;
#(
  parameter int NUM_CH  = NUM_CH_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic            clock,
  input  logic            resetn,
  router_sync_n_if.slave  bus
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              addr_err_q, addr_err_d;
  logic              addr_ok;
  logic [NUM_CH-1:0] write_enb;
  logic              fifo_full;
  logic [NUM_CH-1:0] soft_reset;

  // Header capture; the new address is only seen by the decode next cycle.
  always_comb begin
    addr_d     = addr_q;
    addr_err_d = addr_err_q;
    if (bus.detect_add) begin
      addr_d     = bus.data_in;
      addr_err_d = (int'(bus.data_in) >= NUM_CH);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addr_q     <= '0;
      addr_err_q <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign addr_ok = (int'(addr_q) < NUM_CH);

  // Decode by comparison against each channel index so an out-of-range
  // address never indexes past the end of the full vector.
  always_comb begin
    write_enb = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (addr_ok && (int'(addr_q) == i)) begin
        write_enb[i] = bus.write_enb_reg;
        fifo_full    = bus.full[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    router_timeout #(
      .TIMEOUT (TIMEOUT)
    ) u_timeout (
      .clock        (clock),
      .resetn       (resetn),
      .empty_i      (bus.empty[g]),
      .read_enb_i   (bus.read_enb[g]),
      .soft_reset_o (soft_reset[g])
    );
  end

  assign bus.write_enb  = write_enb;
  assign bus.fifo_full  = fifo_full;
  assign bus.addr_err   = addr_err_q;
  assign bus.vld_out    = ~bus.empty;
  assign bus.soft_reset = soft_reset;

endmodule

// File: tb/tb_router_sync_n.sv
// Directed self-checking bench for router_sync_n: a default instance
// (3 channels, 2-bit address, timeout 30) and a small instance
// (5 channels, 3-bit address, timeout 4) sharing clock and reset.
module tb_router_sync_n;

  logic clock;
  logic resetn;

  int errors = 0;
  int checks = 0;

  router_sync_n_if #(.NUM_CH(3), .ADDR_W(2)) bus ();
  router_sync_n_if #(.NUM_CH(5), .ADDR_W(3)) bus5 ();

  router_sync_n #(.NUM_CH(3), .ADDR_W(2), .TIMEOUT(30)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  router_sync_n #(.NUM_CH(5), .ADDR_W(3), .TIMEOUT(4)) dut5 (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus5.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance n rising edges; leaves time 1 ns after the last edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_sr;

    // ---------------- reset ----------------
    resetn             = 1'b0;
    bus.detect_add     = 1'b0;
    bus.data_in        = '0;
    bus.write_enb_reg  = 1'b0;
    bus.full           = '0;
    bus.empty          = '1;
    bus.read_enb       = '0;
    bus5.detect_add    = 1'b0;
    bus5.data_in       = '0;
    bus5.write_enb_reg = 1'b0;
    bus5.full          = '0;
    bus5.empty         = '1;
    bus5.read_enb      = '0;
    #2;
    check("rst_write_enb",  32'(bus.write_enb),  32'h0);
    check("rst_addr_err",   32'(bus.addr_err),   32'h0);
    check("rst_soft_reset", 32'(bus.soft_reset), 32'h0);
    check("rst_vld_out",    32'(bus.vld_out),    32'h0);
    bus.write_enb_reg = 1'b1;
    #1;
    check("rst_addr0_decode", 32'(bus.write_enb), 32'h1);
    bus.write_enb_reg = 1'b0;
    tick(2);
    resetn = 1'b1;

    // ---------------- valid address decode ----------------
    bus.detect_add = 1'b1;
    bus.data_in    = 2'd2;
    tick(1);
    bus.detect_add    = 1'b0;
    bus.write_enb_reg = 1'b1;
    bus.full          = 3'b100;
    #1;
    check("addr2_write_enb", 32'(bus.write_enb), 32'h4);
    check("addr2_fifo_full", 32'(bus.fifo_full), 32'h1);
    check("addr2_addr_err",  32'(bus.addr_err),  32'h0);
    bus.full = 3'b011;
    #1;
    check("addr2_not_full", 32'(bus.fifo_full), 32'h0);

    // ---------------- same-cycle capture uses old address ----------------
    bus.detect_add = 1'b1;
    bus.data_in    = 2'd1;
    #1;
    check("same_cycle_old_addr", 32'(bus.write_enb), 32'h4);
    tick(1);
    bus.detect_add = 1'b0;
    #1;
    check("next_cycle_new_addr", 32'(bus.write_enb), 32'h2);
    check("addr1_fifo_full",     32'(bus.fifo_full), 32'h1);

    // ---------------- out-of-range address ----------------
    bus.detect_add = 1'b1;
    bus.data_in    = 2'd3;
    tick(1);
    bus.detect_add = 1'b0;
    bus.full       = 3'b111;
    #1;
    check("addr3_write_enb", 32'(bus.write_enb), 32'h0);
    check("addr3_fifo_full", 32'(bus.fifo_full), 32'h0);
    check("addr3_addr_err",  32'(bus.addr_err),  32'h1);
    tick(3);
    check("addr3_err_held", 32'(bus.addr_err), 32'h1);
    bus.detect_add = 1'b1;
    bus.data_in    = 2'd0;
    tick(1);
    bus.detect_add = 1'b0;
    #1;
    check("addr0_err_clear", 32'(bus.addr_err),  32'h0);
    check("addr0_write_enb", 32'(bus.write_enb), 32'h1);
    bus.write_enb_reg = 1'b0;
    bus.full          = '0;
    #1;
    check("no_req_write_enb", 32'(bus.write_enb), 32'h0);

    // ---------------- channel 1 stalls 65 cycles ----------------
    bus.empty = 3'b101;
    #1;
    check("ch1_vld_out", 32'(bus.vld_out), 32'h2);
    for (int k = 1; k <= 65; k++) begin
      tick(1);
      exp_sr = (k == 30 || k == 60) ? 32'h2 : 32'h0;
      check($sformatf("ch1_stall_edge%0d", k), 32'(bus.soft_reset), exp_sr);
    end
    bus.empty = 3'b111;
    tick(1);
    check("ch1_released", 32'(bus.soft_reset), 32'h0);

    // ---------------- channel 0 read on terminal cycle ----------------
    bus.empty = 3'b110;
    for (int k = 1; k <= 29; k++) tick(1);
    check("ch0_pre_read", 32'(bus.soft_reset), 32'h0);
    bus.read_enb = 3'b001;
    tick(1);
    check("ch0_read_suppress", 32'(bus.soft_reset), 32'h0);
    bus.read_enb = 3'b000;
    for (int k = 1; k <= 30; k++) begin
      tick(1);
      exp_sr = (k == 30) ? 32'h1 : 32'h0;
      check($sformatf("ch0_restart_edge%0d", k), 32'(bus.soft_reset), exp_sr);
    end
    bus.empty = 3'b111;
    tick(1);

    // ---------------- reset mid-stall on channel 2 ----------------
    bus.detect_add = 1'b1;
    bus.data_in    = 2'd3;
    tick(1);
    bus.detect_add = 1'b0;
    check("pre_rst_addr_err", 32'(bus.addr_err), 32'h1);
    bus.empty = 3'b011;
    tick(20);
    check("ch2_pre_rst_sr", 32'(bus.soft_reset), 32'h0);
    resetn            = 1'b0;
    bus.write_enb_reg = 1'b1;
    #1;
    check("midrst_addr_err",   32'(bus.addr_err),   32'h0);
    check("midrst_write_enb",  32'(bus.write_enb),  32'h1);
    check("midrst_vld_out",    32'(bus.vld_out),    32'h4);
    check("midrst_soft_reset", 32'(bus.soft_reset), 32'h0);
    bus.write_enb_reg = 1'b0;
    tick(3);
    resetn = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick(1);
      exp_sr = (k == 30) ? 32'h4 : 32'h0;
      check($sformatf("ch2_after_rst_edge%0d", k), 32'(bus.soft_reset), exp_sr);
    end
    bus.empty = 3'b111;
    tick(1);

    // ---------------- 5-channel instance ----------------
    bus5.detect_add = 1'b1;
    bus5.data_in    = 3'd5;
    tick(1);
    bus5.detect_add = 1'b0;
    check("n5_addr5_err", 32'(bus5.addr_err), 32'h1);
    bus5.detect_add    = 1'b1;
    bus5.data_in       = 3'd4;
    tick(1);
    bus5.detect_add    = 1'b0;
    bus5.write_enb_reg = 1'b1;
    bus5.full          = 5'b10000;
    #1;
    check("n5_addr4_err",       32'(bus5.addr_err),  32'h0);
    check("n5_addr4_write_enb", 32'(bus5.write_enb), 32'h10);
    check("n5_addr4_fifo_full", 32'(bus5.fifo_full), 32'h1);
    bus5.write_enb_reg = 1'b0;
    bus5.full          = '0;
    bus5.empty         = 5'b01110;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      exp_sr = (k % 4 == 0) ? 32'h11 : 32'h0;
      check($sformatf("n5_dual_edge%0d", k), 32'(bus5.soft_reset), exp_sr);
    end
    bus5.empty = '1;
    tick(1);
    check("n5_released", 32'(bus5.soft_reset), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
